// File: rtl/gshare_pattern_table_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter encoding and its
// training function, imported by the gshare pattern table.
package bp_pkg;

  typedef logic [1:0] sat2_t;

  localparam sat2_t SAT_SNT   = 2'b00;
  localparam sat2_t SAT_WNT   = 2'b01;
  localparam sat2_t SAT_WT    = 2'b10;
  localparam sat2_t SAT_ST    = 2'b11;
  localparam sat2_t SAT_RESET = SAT_WNT;

  localparam logic [15:0] MISPRED_MAX = 16'hFFFF;

  function automatic sat2_t sat2_next(sat2_t c, logic taken);
    sat2_t n;
    n = c;
    if (taken) begin
      if (c != SAT_ST) n = sat2_t'(c + 2'd1);
    end else begin
      if (c != SAT_SNT) n = sat2_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/gshare_pattern_table_if.sv
// Lookup, resolve and history-drive signals of the gshare pattern table.
// The master modport is the pipeline side, the slave modport is the table.
interface gshare_pattern_table_if #(
  parameter int HIST_W = 4,
  parameter int IDX_W  = 8
);

  logic              pred_valid;
  logic [31:0]       pred_pc;
  logic [HIST_W-1:0] pred_hist;
  logic              pred_resp_valid;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;

  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_pred;

  logic              hist_update;
  logic              hist_in;
  logic [15:0]       mispredict_cnt;

  modport master (
    output pred_valid, pred_pc, pred_hist,
    output upd_valid, upd_idx, upd_taken, upd_pred,
    input  pred_resp_valid, pred_taken, pred_idx,
    input  hist_update, hist_in, mispredict_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, pred_hist,
    input  upd_valid, upd_idx, upd_taken, upd_pred,
    output pred_resp_valid, pred_taken, pred_idx,
    output hist_update, hist_in, mispredict_cnt
  );

endinterface

// File: rtl/gshare_pattern_table_hash.sv
// Combinational gshare index: word-aligned PC bits XOR zero-extended history.
// Kept separate so the tag/BTB path can share the same hash.
module gshare_index_hash #(
  parameter int HIST_W = 4,
  parameter int IDX_W  = 8
) (
  input  logic [31:0]       pc,
  input  logic [HIST_W-1:0] hist,
  output logic [IDX_W-1:0]  idx
);

  // Byte offset and upper PC bits do not take part in the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:IDX_W+2], pc[1:0]};

  assign idx = pc[IDX_W+1:2] ^ IDX_W'(hist);

endmodule

// File: rtl/gshare_pattern_table.sv
// Gshare pattern history table: flop array of 2-bit counters with registered
// lookup, same-cycle update bypass, history drive and misprediction counter.
module gshare_pattern_table
  import bp_pkg::*;
#(
  parameter int HIST_W = 4,
  parameter int IDX_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  gshare_pattern_table_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  sat2_t            counters [DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  sat2_t            upd_next;
  sat2_t            lookup_ctr;

  logic             resp_valid_q;
  logic             taken_q;
  logic [IDX_W-1:0] idx_q;
  logic             hist_update_q;
  logic             hist_in_q;
  logic [15:0]      mispred_q;

  gshare_index_hash #(
    .HIST_W (HIST_W),
    .IDX_W  (IDX_W)
  ) u_hash (
    .pc   (bus.pred_pc),
    .hist (bus.pred_hist),
    .idx  (lookup_idx)
  );

  // A lookup hitting the entry being trained sees the post-update value.
  always_comb begin
    upd_next   = sat2_next(counters[bus.upd_idx], bus.upd_taken);
    lookup_ctr = counters[lookup_idx];
    if (bus.upd_valid && (bus.upd_idx == lookup_idx)) begin
      lookup_ctr = upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        counters[i] <= SAT_RESET;
      end
    end else if (bus.upd_valid) begin
      counters[bus.upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      idx_q        <= '0;
    end else begin
      resp_valid_q <= bus.pred_valid;
      if (bus.pred_valid) begin
        taken_q <= lookup_ctr[1];
        idx_q   <= lookup_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_update_q <= 1'b0;
      hist_in_q     <= 1'b0;
      mispred_q     <= '0;
    end else begin
      hist_update_q <= bus.upd_valid;
      if (bus.upd_valid) begin
        hist_in_q <= bus.upd_taken;
        if ((bus.upd_taken != bus.upd_pred) && (mispred_q != MISPRED_MAX)) begin
          mispred_q <= mispred_q + 16'd1;
        end
      end
    end
  end

  assign bus.pred_resp_valid = resp_valid_q;
  assign bus.pred_taken      = taken_q;
  assign bus.pred_idx        = idx_q;
  assign bus.hist_update     = hist_update_q;
  assign bus.hist_in         = hist_in_q;
  assign bus.mispredict_cnt  = mispred_q;

endmodule
